qam_subcarrier_sched: RTL and testbench

//  Sequences the 4-QAM mapper for the OFDM transmitter. It walks the N_FFT subcarrier bins of each symbol
//  in order and classifies each bin as data, pilot or null. For data bins it pulls one dibit from the bit

---
 rtl/qam_subcarrier_sched_if.sv | 37 +++
 rtl/qam_subcarrier_sched.sv | 171 +++++++++++++++++
 tb/tb_qam_subcarrier_sched.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/qam_subcarrier_sched_if.sv
// rtl/qam_subcarrier_sched_if.sv - control, bit-source, mapper and bin-metadata signals of the subcarrier scheduler
interface qam_subcarrier_sched_if #(
  parameter int N_FFT = 64
) ();
  localparam int BW = $clog2(N_FFT);

  logic          start;
  logic [7:0]    n_sym;
  logic          s_valid;
  logic [1:0]    s_data;
  logic          s_ready;
  logic          out_ready;
  logic          map_en;
  logic          map_valid;
  logic [1:0]    map_data;
  logic          bin_valid;
  logic [BW-1:0] bin_idx;
  logic [1:0]    bin_type;
  logic          sym_last;
  logic          busy;
  logic          done;
  logic          underrun;

  // Controller, bit source and IFFT loader side
  modport master (
    output start, n_sym, s_valid, s_data, out_ready,
    input  s_ready, map_en, map_valid, map_data, bin_valid, bin_idx, bin_type,
           sym_last, busy, done, underrun
  );

  // Scheduler side
  modport slave (
    input  start, n_sym, s_valid, s_data, out_ready,
    output s_ready, map_en, map_valid, map_data, bin_valid, bin_idx, bin_type,
           sym_last, busy, done, underrun
  );
endinterface

// File: rtl/qam_subcarrier_sched.sv
// rtl/qam_subcarrier_sched.sv - walks OFDM bins, feeds the 4-QAM mapper and emits aligned bin metadata
module qam_subcarrier_sched #(
  parameter int         N_FFT        = 64,
  parameter int         GUARD_LO     = 6,
  parameter int         GUARD_HI     = 5,
  parameter int         PILOT_PERIOD = 8,
  parameter int         PILOT_OFFSET = 4,
  parameter logic [1:0] PILOT_DIBIT  = 2'b00,
  parameter int         GAP_CYCLES   = 16
) (
  input logic                 clk,
  input logic                 rst,
  qam_subcarrier_sched_if.slave bus
);
  localparam int BW = $clog2(N_FFT);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [BW-1:0] LO_B   = BW'(GUARD_LO);
  localparam logic [BW-1:0] HI_B   = BW'(N_FFT - GUARD_HI);
  localparam logic [BW-1:0] DC_B   = BW'(N_FFT / 2);
  localparam logic [BW-1:0] LAST_B = BW'(N_FFT - 1);
  localparam logic [BW-1:0] P_MASK = BW'(PILOT_PERIOD - 1);
  localparam logic [BW-1:0] P_OFF  = BW'(PILOT_OFFSET);

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
  typedef enum logic [1:0] {T_DATA = 2'b00, T_PILOT = 2'b01, T_NULL = 2'b10} bin_t;

  state_t        state, state_n;
  bin_t          btype;
  logic [BW-1:0] b;
  logic [7:0]    sym_cnt;
  logic [GW-1:0] gap_cnt;

  logic          adv;
  logic          s_ready_c;
  logic          map_valid_c;
  logic [1:0]    map_data_c;
  logic          start_ok;
  logic          last_bin;
  logic          final_adv;

  logic          bin_valid_q;
  logic [BW-1:0] bin_idx_q;
  logic [1:0]    bin_type_q;
  logic          sym_last_q;
  logic          done_q;
  logic          underrun_q;

  assign start_ok  = (state == IDLE) && bus.start && (bus.n_sym != 8'd0);
  assign last_bin  = (b == LAST_B);
  assign final_adv = adv && last_bin && (sym_cnt == 8'd1);

  // Classify the current bin: guards and DC are null, then pilots on their comb, rest data
  always_comb begin
    btype = T_DATA;
    if (b < LO_B || b >= HI_B || b == DC_B) begin
      btype = T_NULL;
    end else if ((b & P_MASK) == P_OFF) begin
      btype = T_PILOT;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FSM next state plus the combinational mapper drive; only data bins wait on the bit source
  always_comb begin
    state_n     = state;
    adv         = 1'b0;
    s_ready_c   = 1'b0;
    map_valid_c = 1'b0;
    map_data_c  = 2'b00;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_n = RUN;
        end
      end
      RUN: begin
        s_ready_c   = (btype == T_DATA) && bus.out_ready;
        adv         = bus.out_ready && ((btype != T_DATA) || bus.s_valid);
        map_valid_c = adv && (btype != T_NULL);
        if (btype == T_DATA) begin
          map_data_c = bus.s_data;
        end else if (btype == T_PILOT) begin
          map_data_c = PILOT_DIBIT;
        end
        if (adv && last_bin) begin
          if (sym_cnt == 8'd1) begin
            state_n = IDLE;
          end else if (GAP_CYCLES > 0) begin
            state_n = GAP;
          end else begin
            state_n = RUN;
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_n = RUN;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Bin, symbol and gap counters plus the sticky underrun flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b          <= '0;
      sym_cnt    <= '0;
      gap_cnt    <= '0;
      underrun_q <= 1'b0;
    end else begin
      if (start_ok) begin
        b          <= '0;
        sym_cnt    <= bus.n_sym;
        underrun_q <= 1'b0;
      end
      if (adv) begin
        b <= b + 1'b1;
        if (last_bin) begin
          sym_cnt <= sym_cnt - 8'd1;
        end
      end
      if (state == RUN && btype == T_DATA && bus.out_ready && !bus.s_valid) begin
        underrun_q <= 1'b1;
      end
      if (state == RUN && state_n == GAP) begin
        gap_cnt <= GW'(GAP_CYCLES - 1);
      end else if (state == GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

  // Metadata registered from the advance cycle so it lines up with the mapper output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_valid_q <= 1'b0;
      bin_idx_q   <= '0;
      bin_type_q  <= 2'b00;
      sym_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      bin_valid_q <= adv;
      bin_idx_q   <= adv ? b : '0;
      bin_type_q  <= adv ? btype : 2'b00;
      sym_last_q  <= adv && last_bin;
      done_q      <= final_adv;
    end
  end

  assign bus.s_ready   = s_ready_c;
  assign bus.map_en    = map_valid_c;
  assign bus.map_valid = map_valid_c;
  assign bus.map_data  = map_data_c;
  assign bus.bin_valid = bin_valid_q;
  assign bus.bin_idx   = bin_idx_q;
  assign bus.bin_type  = bin_type_q;
  assign bus.sym_last  = sym_last_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.underrun  = underrun_q;
endmodule

// File: tb/tb_qam_subcarrier_sched.sv
// tb/tb_qam_subcarrier_sched.sv - randomized self-checking bench for qam_subcarrier_sched
module tb_qam_subcarrier_sched;
  localparam int         N   = 64;
  localparam int         GLO = 6;
  localparam int         GHI = 5;
  localparam int         PP  = 8;
  localparam int         PO  = 4;
  localparam int         GAP = 16;
  localparam logic [1:0] PD  = 2'b00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qam_subcarrier_sched_if #(.N_FFT(N)) bus ();

  qam_subcarrier_sched #(
    .N_FFT(N), .GUARD_LO(GLO), .GUARD_HI(GHI), .PILOT_PERIOD(PP),
    .PILOT_OFFSET(PO), .PILOT_DIBIT(PD), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int consumed = 0;
  int since_last = -1;
  int last_gap = -1;
  int start_cyc = 0;

  // reference model: run phase (0 idle, 1 run, 2 gap) and flat bin position in the run
  int m_phase = 0;
  int m_pos = 0;
  int m_total = 0;
  int m_gap = 0;
  bit m_under = 0;
  bit p_bv = 0;
  bit p_last = 0;
  bit p_done = 0;
  int p_idx = 0;
  int p_type = 0;

  // stimulus knobs
  int p_sv = 100;
  int p_or = 100;
  int sv_bin = -1;
  int sv_left = 0;
  int or_bin = -1;
  int or_left = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int cls(input int b);
    if (b < GLO || b >= N - GHI || b == N / 2) return 2;
    if (b % PP == PO) return 1;
    return 0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // compare DUT against the model every cycle, then step the model
  always @(negedge clk) begin
    int b, t;
    bit adv, e_sr, e_mv;
    int e_md;
    if (rst) begin
      chk("rst_outs", int'({bus.s_ready, bus.map_en, bus.map_valid, bus.map_data, bus.bin_valid,
                           bus.bin_idx, bus.bin_type, bus.sym_last, bus.busy, bus.done, bus.underrun}), 0);
      m_phase = 0; m_pos = 0; m_total = 0; m_gap = 0; m_under = 0;
      p_bv = 0; p_last = 0; p_done = 0; since_last = -1;
    end else begin
      b = m_pos % N;
      t = cls(b);
      adv = 0; e_sr = 0; e_mv = 0; e_md = 0;
      if (m_phase == 1) begin
        e_sr = (t == 0) && bus.out_ready;
        adv  = bus.out_ready && (t != 0 || bus.s_valid);
        e_mv = adv && (t != 2);
        e_md = (t == 0) ? int'(bus.s_data) : int'(PD);
      end
      chk("s_ready", int'(bus.s_ready), int'(e_sr));
      chk("map_valid", int'(bus.map_valid), int'(e_mv));
      chk("map_en", int'(bus.map_en), int'(e_mv));
      if (e_mv && bus.map_valid) chk("map_data", int'(bus.map_data), e_md);
      chk("bin_valid", int'(bus.bin_valid), int'(p_bv));
      if (p_bv && bus.bin_valid) begin
        chk("bin_idx", int'(bus.bin_idx), p_idx);
        chk("bin_type", int'(bus.bin_type), p_type);
        chk("sym_last", int'(bus.sym_last), int'(p_last));
      end
      chk("busy", int'(bus.busy), int'(m_phase != 0));
      chk("done", int'(bus.done), int'(p_done));
      chk("underrun", int'(bus.underrun), int'(m_under));

      if (bus.done) begin done_cnt++; done_cyc = cyc; end
      if (bus.s_valid && bus.s_ready) consumed++;
      if (bus.bin_valid && bus.sym_last) since_last = 0;
      else if (!bus.bin_valid && since_last >= 0) since_last++;
      else if (bus.bin_valid && since_last >= 0) begin last_gap = since_last; since_last = -1; end

      p_bv = adv; p_idx = b; p_type = t; p_last = (b == N - 1);
      p_done = adv && (m_pos == m_total - 1);
      if (m_phase == 1 && t == 0 && bus.out_ready && !bus.s_valid) m_under = 1;
      case (m_phase)
        0: if (bus.start && bus.n_sym != 0) begin
             m_phase = 1; m_pos = 0; m_total = int'(bus.n_sym) * N; m_under = 0;
           end
        1: if (adv) begin
             m_pos++;
             if (m_pos == m_total) begin m_phase = 0; m_pos = 0; end
             else if (b == N - 1 && GAP > 0) begin m_phase = 2; m_gap = GAP; end
           end
        default: begin m_gap--; if (m_gap == 0) m_phase = 1; end
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.s_valid = ($urandom_range(99) < p_sv);
    bus.s_data = 2'($urandom);
    bus.out_ready = ($urandom_range(99) < p_or);
    if (m_phase == 1 && m_pos == sv_bin && sv_left > 0) begin bus.s_valid = 1'b0; sv_left--; end
    if (m_phase == 1 && m_pos == or_bin && or_left > 0) begin bus.out_ready = 1'b0; or_left--; end
  endtask

  task automatic kick(input int n);
    step();
    bus.start = 1'b1;
    bus.n_sym = 8'(n);
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int bound);
    int d0 = done_cnt;
    int k = 0;
    while (done_cnt == d0 && k < bound) begin step(); k++; end
    chk("done_seen", int'(done_cnt != d0), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, np, nn, d0, c0, n;
    bus.start = 0; bus.n_sym = 0; bus.s_valid = 0; bus.s_data = 0; bus.out_ready = 0;

    nd = 0; np = 0; nn = 0;
    for (int b = 0; b < N; b++) begin
      case (cls(b)) 0: nd++; 1: np++; default: nn++; endcase
    end
    chk("model_data_bins", nd, 46);
    chk("model_pilot_bins", np, 6);
    chk("model_null_bins", nn, 12);
    chk("model_bin12", cls(12), 1);
    chk("model_bin52", cls(52), 1);
    chk("model_bin32", cls(32), 2);
    chk("model_bin59", cls(59), 2);
    chk("model_bin58", cls(58), 0);

    repeat (3) @(posedge clk);
    #2;
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_bin_valid", int'(bus.bin_valid), 0);
    @(posedge clk); #1; rst = 1'b0;

    // single symbol at full rate
    d0 = done_cnt; c0 = consumed;
    kick(1); wait_done(200);
    chk("t1_latency", done_cyc - start_cyc, 65);
    chk("t1_dibits", consumed - c0, 46);
    chk("t1_done_once", done_cnt - d0, 1);

    // two symbols with the cyclic-prefix gap
    d0 = done_cnt; last_gap = -1;
    kick(2); wait_done(400);
    chk("t2_gap", last_gap, 16);
    chk("t2_latency", done_cyc - start_cyc, 145);
    chk("t2_done_once", done_cnt - d0, 1);

    // bit source dry for 5 cycles at bin 7
    c0 = consumed; sv_bin = 7; sv_left = 5;
    kick(1); wait_done(200);
    chk("t3_underrun", int'(bus.underrun), 1);
    chk("t3_latency", done_cyc - start_cyc, 70);
    chk("t3_dibits", consumed - c0, 46);

    // loader backpressure for 3 cycles at bin 20
    c0 = consumed; or_bin = 20; or_left = 3;
    kick(1); wait_done(200);
    chk("t4_latency", done_cyc - start_cyc, 68);
    chk("t4_dibits", consumed - c0, 46);
    chk("t4_no_underrun", int'(bus.underrun), 0);

    // reset at bin 30 after an underrun, then a clean restart
    sv_bin = 7; sv_left = 2;
    kick(1);
    for (int k = 0; k < 100 && !(m_phase == 1 && m_pos == 30); k++) step();
    chk("t5_reached_bin30", m_pos, 30);
    chk("t5_underrun_before", int'(bus.underrun), 1);
    rst = 1'b1;
    #2;
    chk("t5_rst_outs", int'({bus.s_ready, bus.map_valid, bus.map_data, bus.bin_valid, bus.bin_idx,
                             bus.bin_type, bus.sym_last, bus.busy, bus.done, bus.underrun}), 0);
    step(); step();
    rst = 1'b0;
    kick(1); wait_done(200);
    chk("t5_latency", done_cyc - start_cyc, 65);
    chk("t5_underrun_clear", int'(bus.underrun), 0);

    // start while busy, then start with n_sym=0
    d0 = done_cnt;
    kick(1);
    repeat (10) step();
    bus.start = 1'b1; bus.n_sym = 8'd5;
    wait_done(200);
    chk("t6_latency", done_cyc - start_cyc, 65);
    repeat (5) step();
    chk("t6_busy_after", int'(bus.busy), 0);
    chk("t6_done_once", done_cnt - d0, 1);
    d0 = done_cnt;
    kick(0);
    repeat (5) step();
    chk("t6_nsym0_busy", int'(bus.busy), 0);
    chk("t6_nsym0_done", done_cnt - d0, 0);

    // randomized runs
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 3));
      p_sv = int'($urandom_range(50, 100));
      p_or = int'($urandom_range(40, 100));
      d0 = done_cnt; c0 = consumed;
      kick(n); wait_done(4000);
      chk("rand_dibits", consumed - c0, 46 * n);
      chk("rand_done_once", done_cnt - d0, 1);
    end
    p_sv = 100; p_or = 100;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
